pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Reset and lock-supervision controller for the HDMI test PLL (50 MHz reference in, 135 MHz / 27 MHz out). It runs on the reference clock and drives the PLL reset. It waits for a stable lock, retries on lock timeout and restarts the PLL on lock loss or on request. It issues one downstream reset for the video logic; consumers re-synchronize that reset into the outclk domains themselves.

## Interface
Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.

Ports:
- refclk  in  1  reference clock, 50 MHz; the sole clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  raw PLL lock, asynchronous to refclk.
- relock_req  in  1  single-cycle request to restart the PLL.
- pll_rst  out  1  reset to the PLL `rst` input.
- sys_reset  out  1  downstream reset, active high.
- ready  out  1  high only in RUN.
- lock_lost  out  1  one-cycle pulse on lock loss while in RUN.
- retry_count  out  4  lock timeouts since reset, saturating at 15.

## Operation
- `pll_locked` passes through a 2-FF synchronizer to give `locked_s`. Only `locked_s` is used internally.
- A single down-counter, sized for the largest parameter, serves all timed states.
- RESET_PLL:
  - pll_rst=1, sys_reset=1, ready=0.
  - Lasts exactly RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - pll_rst=0, sys_reset=1.
  - If `locked_s`=1, go to STABLE with the counter loaded.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles: increment retry_count (saturating) and go to RESET_PLL.
- STABLE:
  - pll_rst=0, sys_reset=1.
  - If `locked_s` drops, return to WAIT_LOCK with a fresh timeout. This is not a retry: no count increment.
  - After LOCK_STABLE_CYCLES consecutive locked cycles, go to RUN.
- RUN:
  - sys_reset=0, ready=1.
  - If `locked_s`=0: pulse lock_lost for one cycle and go to RESET_PLL.
- relock_req:
  - In WAIT_LOCK, STABLE or RUN: go to RESET_PLL. retry_count is unchanged and no lock_lost pulse is issued.
  - Ignored in RESET_PLL; the pulse is not restarted.
- Simultaneous events:
  - Lock loss plus relock_req in RUN: exactly one lock_lost pulse, then RESET_PLL.
  - Timeout expiry and `locked_s` rising in the same cycle: lock wins (go to STABLE, no increment).
- `rst` asserted mid-operation forces all state and outputs to their reset values immediately.

## Timing
- Reset values: state RESET_PLL, pll_rst=1, sys_reset=1, ready=0, lock_lost=0, retry_count=0, synchronizer=0.
- All outputs are registered and change on the refclk edge that enters the new state.
- After `rst` falls: pll_rst stays high for RST_PULSE_CYCLES cycles, then goes low.
- `pll_locked` rising to `locked_s`: 2 cycles.
- `locked_s` rising to ready=1 / sys_reset=0: LOCK_STABLE_CYCLES+1 cycles.
- `pll_locked` falling in RUN: lock_lost and pll_rst=1 arrive 3 cycles later (2 sync + 1).
- sys_reset and ready change on the same edge; they are never both asserted or both deasserted.

## Configuration
- PLL_SEQ_RETRY_LIMIT_EN defined:
  - After the 8th timeout (retry_count=8), enter FAIL instead of RESET_PLL.
  - In FAIL: pll_rst=1, sys_reset=1, ready=0.
  - FAIL exits only by relock_req, which clears retry_count to 0 and enters RESET_PLL, or by `rst`.
- PLL_SEQ_RETRY_LIMIT_EN undefined: retries indefinitely, retry_count saturates at 15, and there is no FAIL state.

## Test plan
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8.
- Normal bring-up: release rst, raise pll_locked 10 cycles later. Required: pll_rst high for exactly 4 cycles, then ready=1 and sys_reset=0 exactly 11 cycles after the pll_locked edge; retry_count=0.
- Timeouts: hold pll_locked=0. Required: pll_rst pulses every 24 cycles. retry_count stops at 8 with FAIL when PLL_SEQ_RETRY_LIMIT_EN is defined; otherwise it saturates at 15.
- Lock glitch: in STABLE, drop pll_locked for 1 cycle at stable count 5. Required: no ready, no retry_count increment; ready appears 11 cycles after lock returns.
- Lock loss in RUN: drop pll_locked. Required: one-cycle lock_lost pulse, with ready=0, sys_reset=1 and pll_rst=1 three cycles after the edge.
- relock_req coincident with lock loss in RUN: exactly one lock_lost pulse and a 4-cycle pll_rst pulse. relock_req issued during RESET_PLL does not extend the pulse.
- Async rst asserted mid-STABLE: all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Reset and lock-supervision controller for the HDMI test PLL. It runs on the
// 50 MHz reference clock. It pulses the PLL reset, then waits for a stable
// lock. It retries when the lock times out and restarts the PLL on lock loss
// or on request. It also drives a single downstream reset for the video
// logic.
//
// Optional feature macro: PLL_SEQ_RETRY_LIMIT_EN
//   defined   : after the 8th lock timeout the sequencer parks in FAIL
//               (PLL held in reset) until relock_req or rst.
//   undefined : retries forever; retry_count saturates at 15.
//
// Parameters:
//   RST_PULSE_CYCLES    refclk cycles pll_rst is held high per attempt (>=1)
//   LOCK_TIMEOUT_CYCLES cycles allowed in WAIT_LOCK before a retry
//   LOCK_STABLE_CYCLES  consecutive locked cycles required before release
//
// Ports:
//   refclk       in   reference clock, sole clock
//   rst          in   asynchronous active-high reset
//   pll_locked   in   raw PLL lock (asynchronous, synchronized here)
//   relock_req   in   single-cycle request to restart the PLL
//   pll_rst      out  reset to the PLL
//   sys_reset    out  downstream reset, active high
//   ready        out  high only in RUN
//   lock_lost    out  one-cycle pulse on lock loss while in RUN
//   retry_count  out  lock timeouts since reset, saturating at 15
// ---------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    // One down-counter serves every timed state, so size it for the longest.
    localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The counter is loaded with N-1 and the state exits when it reads zero,
    // so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        ,
        ST_FAIL      = 3'd4
`endif
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       sync_r;
    logic             locked_s;

    assign locked_s = sync_r[1];

    // Two-flop synchronizer bringing the raw PLL lock into the refclk domain.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll_locked};
        end
    end

    // Sequencer FSM; every output is registered and set on the entering edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RESET_PLL;
            cnt_r       <= RST_LOAD;
            pll_rst     <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            lock_lost <= 1'b0;
            case (state_r)
                ST_RESET_PLL: begin
                    // relock_req is deliberately ignored: the pulse is not restarted.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= TO_LOAD;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (relock_req) begin
                        state_r   <= ST_RESET_PLL;
                        cnt_r     <= RST_LOAD;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else if (locked_s) begin
                        // Lock beats a coincident timeout expiry.
                        state_r <= ST_STABLE;
                        cnt_r   <= STB_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        if (retry_count != 4'd15) begin
                            retry_count <= retry_count + 4'd1;
                        end else begin
                            retry_count <= retry_count;
                        end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        if (retry_count == 4'd7) begin
                            state_r <= ST_FAIL;
                        end else begin
                            state_r <= ST_RESET_PLL;
                        end
`else
                        state_r <= ST_RESET_PLL;
`endif
                        cnt_r     <= RST_LOAD;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_STABLE: begin
                    if (relock_req) begin
                        state_r   <= ST_RESET_PLL;
                        cnt_r     <= RST_LOAD;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else if (!locked_s) begin
                        // A lock glitch is not a retry: fresh timeout, no count.
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= TO_LOAD;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r   <= ST_RUN;
                        sys_reset <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_RUN: begin
                    if (!locked_s || relock_req) begin
                        // Lock loss wins over a coincident request: one pulse only.
                        lock_lost <= ~locked_s;
                        state_r   <= ST_RESET_PLL;
                        cnt_r     <= RST_LOAD;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end

`ifdef PLL_SEQ_RETRY_LIMIT_EN
                ST_FAIL: begin
                    if (relock_req) begin
                        state_r     <= ST_RESET_PLL;
                        cnt_r       <= RST_LOAD;
                        retry_count <= 4'd0;
                    end else begin
                        state_r <= ST_FAIL;
                    end
                end
`endif

                default: begin
                    state_r   <= ST_RESET_PLL;
                    cnt_r     <= RST_LOAD;
                    pll_rst   <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Self-checking bench for pll_reset_sequencer with small timing parameters.
// A phase/elapsed-time reference model runs in step with the DUT. Directed
// scenarios measure the key latencies with plain step counters, and a
// randomized phase follows them.
// Honours PLL_SEQ_RETRY_LIMIT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam bit LIMIT     = 1'b1;
    localparam int RETRY_END = 8;
`else
    localparam bit LIMIT     = 1'b0;
    localparam int RETRY_END = 15;
`endif

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_FAIL = 4;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // reference model state
    int m_phase;
    int m_el;
    int m_retry;
    bit m_lost;
    bit h0;
    bit h1;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (ST)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_RST;
        m_el    = 0;
        m_retry = 0;
        m_lost  = 1'b0;
        h0      = 1'b0;
        h1      = 1'b0;
    endtask

    // One refclk edge of the reference model. The lock seen by the
    // controller is the pll_locked value sampled two edges earlier.
    task automatic model_edge(input logic lk, input logic rq);
        int e;
        int nxt;
        bit ls;
        ls     = h1;
        h1     = h0;
        h0     = lk;
        e      = m_el + 1;
        nxt    = m_phase;
        m_lost = 1'b0;
        case (m_phase)
            PH_RST:  if (e == RP) nxt = PH_WAIT;
            PH_WAIT: begin
                if (rq) nxt = PH_RST;
                else if (ls) nxt = PH_STB;
                else if (e == TO) begin
                    if (m_retry < 15) m_retry++;
                    nxt = (LIMIT && m_retry == 8) ? PH_FAIL : PH_RST;
                end
            end
            PH_STB: begin
                if (rq) nxt = PH_RST;
                else if (!ls) nxt = PH_WAIT;
                else if (e == ST) nxt = PH_RUN;
            end
            PH_RUN: begin
                if (!ls) begin
                    m_lost = 1'b1;
                    nxt    = PH_RST;
                end else if (rq) nxt = PH_RST;
            end
            PH_FAIL: begin
                if (rq) begin
                    m_retry = 0;
                    nxt     = PH_RST;
                end
            end
            default: nxt = PH_RST;
        endcase
        m_el    = (nxt == m_phase) ? e : 0;
        m_phase = nxt;
    endtask

    task automatic compare_outputs();
        check("pll_rst",     pll_rst,     (m_phase == PH_RST || m_phase == PH_FAIL));
        check("sys_reset",   sys_reset,   (m_phase != PH_RUN));
        check("ready",       ready,       (m_phase == PH_RUN));
        check("lock_lost",   lock_lost,   m_lost);
        check("retry_count", retry_count, m_retry);
    endtask

    // Apply inputs for one cycle, advance model on the edge, compare 1 ns later.
    task automatic step(input logic lk, input logic rq);
        pll_locked = lk;
        relock_req = rq;
        @(posedge refclk);
        model_edge(lk, rq);
        #1;
        relock_req = 1'b0;
        cyc++;
        compare_outputs();
    endtask

    initial begin
        int n;
        int lost_cnt;
        int rst_cnt;
        int last_rise;
        int rises;
        logic prev_rst;
        logic lk;
        logic rq;

        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        check("reset_pll_rst",   pll_rst,     1'b1);
        check("reset_sys_reset", sys_reset,   1'b1);
        check("reset_ready",     ready,       1'b0);
        check("reset_lock_lost", lock_lost,   1'b0);
        check("reset_retry",     retry_count, 4'd0);
        rst = 1'b0;

        // Normal bring-up: pll_rst high for RP cycles, lock raised 10 cycles after release.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            if (i == RP - 2) check("rst_pulse_last", pll_rst, 1'b1);
            if (i == RP - 1) check("rst_pulse_end",  pll_rst, 1'b0);
        end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("bringup_latency", n, 11);
        check("bringup_retry", retry_count, 4'd0);

        // Lock loss in RUN: lock_lost and pll_rst three cycles after the edge.
        n = 0;
        while (lock_lost !== 1'b1 && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        check("lost_latency", n, 3);
        check("lost_pll_rst", pll_rst, 1'b1);
        check("lost_ready", ready, 1'b0);
        check("lost_sys_reset", sys_reset, 1'b1);
        step(1'b0, 1'b0);
        check("lost_pulse_width", lock_lost, 1'b0);

        // Back to RUN, then lock loss coincident with relock_req.
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("rerun_ready", ready, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        lost_cnt = int'(lock_lost);
        rst_cnt  = int'(pll_rst);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i == 1));      // request during RESET_PLL must be ignored
            lost_cnt += int'(lock_lost);
            rst_cnt  += int'(pll_rst);
        end
        check("coinc_lost_pulses", lost_cnt, 1);
        check("coinc_rst_cycles",  rst_cnt,  RP);

        // Lock glitch in STABLE: one-cycle drop, ready 11 cycles after return.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            step(1'b1, 1'b0);
            n++;
        end
        check("glitch_latency", n, 11);
        check("glitch_retry", retry_count, 4'd0);

        // Timeouts: pll_rst rises every RP+TO cycles; retry_count ends at its limit.
        n = 0;
        while (lock_lost !== 1'b1 && n < 10) begin
            step(1'b0, 1'b0);
            n++;
        end
        last_rise = cyc;
        rises     = 0;
        prev_rst  = pll_rst;
        for (int i = 0; i < 17 * (RP + TO); i++) begin
            step(1'b0, 1'b0);
            if (pll_rst === 1'b1 && prev_rst === 1'b0) begin
                rises++;
                if (rises <= 6) check("retry_period", cyc - last_rise, RP + TO);
                last_rise = cyc;
            end
            prev_rst = pll_rst;
        end
        check("retry_final", retry_count, RETRY_END);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        check("fail_pll_rst", pll_rst, 1'b1);
        step(1'b0, 1'b1);
        check("fail_exit_retry", retry_count, 4'd0);
`endif

        // Async rst in STABLE: outputs return to reset values without an edge.
        n = 0;
        while (m_phase != PH_STB && n < 60) begin
            step(1'b1, 1'b0);
            n++;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        rst = 1'b1;
        #2;
        check("async_pll_rst",   pll_rst,     1'b1);
        check("async_sys_reset", sys_reset,   1'b1);
        check("async_ready",     ready,       1'b0);
        check("async_lock_lost", lock_lost,   1'b0);
        check("async_retry",     retry_count, 4'd0);
        model_reset();
        @(posedge refclk);
        #1;
        rst = 1'b0;

        // Randomized phase: slow-toggling lock with occasional relock requests.
        lk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            rq = ($urandom_range(0, 49) == 0);
            step(lk, rq);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
